// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback sources:
//   req0 (ALU) and req1 (load/store unit). The two requesters are arbitrated
//   round-robin over a valid/ready handshake. The granted write is registered
//   into a one-entry output stage that drives the register file. A pending-write
//   scoreboard tells decode which source registers still have a write in flight.
//
// Ports:
//   i_clk                       clock, all state updates on the rising edge
//   i_reset                     synchronous active-high reset
//   i_req0_valid/index/data     ALU writeback request
//   o_req0_ready                grant to req0 (combinational)
//   i_req1_valid/index/data     LSU writeback request
//   o_req1_ready                grant to req1 (combinational)
//   o_wr_en/o_wr_index/o_wr_data  register file write port (registered)
//   i_issue_en, i_issue_rd      decode issued an instruction that writes issue_rd
//   i_rd_index1, i_rd_index2    source registers being decoded
//   o_rd_hazard1, o_rd_hazard2  source register has a pending write (combinational)
//   o_busy                      scoreboard bit vector (registered)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                        i_clk,
    input  logic                        i_reset,

    input  logic                        i_req0_valid,
    input  logic [ADDR_WIDTH-1:0]       i_req0_index,
    input  logic [DATA_WIDTH-1:0]       i_req0_data,
    output logic                        o_req0_ready,

    input  logic                        i_req1_valid,
    input  logic [ADDR_WIDTH-1:0]       i_req1_index,
    input  logic [DATA_WIDTH-1:0]       i_req1_data,
    output logic                        o_req1_ready,

    output logic                        o_wr_en,
    output logic [ADDR_WIDTH-1:0]       o_wr_index,
    output logic [DATA_WIDTH-1:0]       o_wr_data,

    input  logic                        i_issue_en,
    input  logic [ADDR_WIDTH-1:0]       i_issue_rd,
    input  logic [ADDR_WIDTH-1:0]       i_rd_index1,
    input  logic [ADDR_WIDTH-1:0]       i_rd_index2,
    output logic                        o_rd_hazard1,
    output logic                        o_rd_hazard2,
    output logic [(2**ADDR_WIDTH)-1:0]  o_busy
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    // r_last_gnt1 = 1 when req1 received the most recent grant. Resetting it
    // to 1 hands priority to req0 first.
    logic                   r_last_gnt1;
    logic                   r_wr_en;
    logic [ADDR_WIDTH-1:0]  r_wr_index;
    logic [DATA_WIDTH-1:0]  r_wr_data;
    logic [NUM_REGS-1:0]    r_busy;

    logic                   w_grant0;
    logic                   w_grant1;
    logic                   w_xfer;
    logic [ADDR_WIDTH-1:0]  w_sel_index;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic [NUM_REGS-1:0]    w_busy_next;

    // Grants depend only on the valids, the priority pointer and reset, never
    // on index or data, so there is no data-to-ready combinational path.
    assign w_grant0 = !i_reset && i_req0_valid && (!i_req1_valid ||  r_last_gnt1);
    assign w_grant1 = !i_reset && i_req1_valid && (!i_req0_valid || !r_last_gnt1);
    assign w_xfer   = w_grant0 || w_grant1;

    assign o_req0_ready = w_grant0;
    assign o_req1_ready = w_grant1;

    assign w_sel_index = w_grant1 ? i_req1_index : i_req0_index;
    assign w_sel_data  = w_grant1 ? i_req1_data  : i_req0_data;

    // Scoreboard next state. The clear is applied before the set so that a
    // same-cycle issue to the retiring index keeps the bit: the newer producer
    // is still outstanding.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_busy_next = r_busy;
        if (w_xfer && (w_sel_index != '0)) begin
            w_busy_next[w_sel_index] = 1'b0;
        end
        if (i_issue_en && (i_issue_rd != '0)) begin
            w_busy_next[i_issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;  // x0 is never written, so never pending
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_gnt1 <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_index  <= '0;
            r_wr_data   <= '0;
            r_busy      <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_xfer) begin
                r_last_gnt1 <= w_grant1;
                // A write to x0 is accepted but never reaches the register file.
                r_wr_en     <= (w_sel_index != '0);
                r_wr_index  <= w_sel_index;
                r_wr_data   <= w_sel_data;
            end else begin
                r_wr_en     <= 1'b0;
            end
        end
    end

    assign o_wr_en    = r_wr_en;
    assign o_wr_index = r_wr_index;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = r_busy;

    // A source is hazardous while its producer is outstanding, and also in the
    // cycle its write sits in the output stage before the register file has it.
    assign o_rd_hazard1 = (i_rd_index1 != '0) &&
                          (r_busy[i_rd_index1] || (r_wr_en && (r_wr_index == i_rd_index1)));
    assign o_rd_hazard2 = (i_rd_index2 != '0) &&
                          (r_busy[i_rd_index2] || (r_wr_en && (r_wr_index == i_rd_index2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed stimulus for regfile_wb_arbiter. A behavioural model (priority
// owner, pending output-stage write, busy vector) is checked against the DUT
// every cycle on the falling edge; hand-computed literals pin the model.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0_valid, req1_valid;
    logic [AW-1:0]  req0_index, req1_index;
    logic [DW-1:0]  req0_data,  req1_data;
    logic           req0_ready, req1_ready;
    logic           wr_en;
    logic [AW-1:0]  wr_index;
    logic [DW-1:0]  wr_data;
    logic           issue_en;
    logic [AW-1:0]  issue_rd;
    logic [AW-1:0]  rd_index1, rd_index2;
    logic           rd_hazard1, rd_hazard2;
    logic [31:0]    busy;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req0_valid (req0_valid),
        .i_req0_index (req0_index),
        .i_req0_data  (req0_data),
        .o_req0_ready (req0_ready),
        .i_req1_valid (req1_valid),
        .i_req1_index (req1_index),
        .i_req1_data  (req1_data),
        .o_req1_ready (req1_ready),
        .o_wr_en      (wr_en),
        .o_wr_index   (wr_index),
        .o_wr_data    (wr_data),
        .i_issue_en   (issue_en),
        .i_issue_rd   (issue_rd),
        .i_rd_index1  (rd_index1),
        .i_rd_index2  (rd_index2),
        .o_rd_hazard1 (rd_hazard1),
        .o_rd_hazard2 (rd_hazard2),
        .o_busy       (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_prio     = 0;      // requester that wins when both are valid
    logic        m_wr_en    = 1'b0;
    logic [4:0]  m_wr_index = '0;
    logic [31:0] m_wr_data  = '0;
    logic [31:0] m_busy     = '0;

    // Who should be granted this cycle: -1 none, else requester number.
    function automatic int exp_grant();
        if (reset)                    return -1;
        if (req0_valid && req1_valid) return m_prio;
        if (req0_valid)               return 0;
        if (req1_valid)               return 1;
        return -1;
    endfunction

    function automatic logic exp_hazard(input logic [4:0] rd);
        return (rd != 0) && (m_busy[rd] || (m_wr_en && m_wr_index == rd));
    endfunction

    // Compare, then advance the model to what the next rising edge produces.
    // Inputs only change just after a rising edge, so they are settled here.
    always @(negedge clk) begin
        automatic int          g = exp_grant();
        automatic logic [4:0]  k;
        automatic logic [31:0] d;
        if (cmp_on) begin
            check("ready0",   req0_ready, g == 0);
            check("ready1",   req1_ready, g == 1);
            check("wr_en",    wr_en,      m_wr_en);
            check("wr_index", wr_index,   m_wr_index);
            check("wr_data",  wr_data,    m_wr_data);
            check("busy",     busy,       m_busy);
            check("hazard1",  rd_hazard1, exp_hazard(rd_index1));
            check("hazard2",  rd_hazard2, exp_hazard(rd_index2));
        end
        if (reset) begin
            m_prio = 0; m_wr_en = 0; m_wr_index = 0; m_wr_data = 0; m_busy = 0;
        end else begin
            if (g >= 0) begin
                k = (g == 1) ? req1_index : req0_index;
                d = (g == 1) ? req1_data  : req0_data;
                if (k != 0) m_busy[k] = 1'b0;
                m_wr_en    = (k != 0);
                m_wr_index = k;
                m_wr_data  = d;
                m_prio     = 1 - g;
            end else begin
                m_wr_en = 1'b0;
            end
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    initial begin
        reset = 1; issue_en = 0; issue_rd = 0;
        req0_valid = 1; req0_index = 5'd1; req0_data = 32'h11;
        req1_valid = 1; req1_index = 5'd2; req1_data = 32'h22;
        rd_index1 = 5'd1; rd_index2 = 5'd2;

        // Reset held with both requesters valid.
        for (int i = 0; i < 3; i++) begin
            step();
            cmp_on = 1'b1;
            look();
            check("rst_ready0", req0_ready, 1'b0);
            check("rst_ready1", req1_ready, 1'b0);
            check("rst_wr_en",  wr_en,      1'b0);
            check("rst_busy",   busy,       32'h0);
            check("rst_haz1",   rd_hazard1, 1'b0);
        end
        step(); reset = 0;
        look();
        check("rel_ready0", req0_ready, 1'b1);
        check("rel_ready1", req1_ready, 1'b0);
        step();
        look();
        check("rel2_ready1", req1_ready, 1'b1);
        check("rel2_wr_idx", wr_index,   5'd1);
        step(); req0_valid = 0; req1_valid = 0;
        look();
        check("rel3_wr_idx", wr_index, 5'd2);

        // Single requester: req1 only.
        step(); req1_valid = 1; req1_index = 5'd5; req1_data = 32'h0000_00A5;
        look();
        check("single_ready1", req1_ready, 1'b1);
        step(); req1_valid = 0;
        look();
        check("single_wr_en",  wr_en,    1'b1);
        check("single_wr_idx", wr_index, 5'd5);
        check("single_wr_dat", wr_data,  32'hA5);
        step();
        look();
        check("single_wr_off", wr_en, 1'b0);

        // Round-robin with both valid for four cycles.
        step();
        req0_valid = 1; req0_index = 5'd1; req0_data = 32'h1111_0001;
        req1_valid = 1; req1_index = 5'd2; req1_data = 32'h2222_0002;
        for (int i = 0; i < 4; i++) begin
            look();
            check("rr_ready0", req0_ready, (i % 2) == 0);
            check("rr_ready1", req1_ready, (i % 2) == 1);
            check("rr_onehot", req0_ready & req1_ready, 1'b0);
            if (i > 0) check("rr_wr_idx", wr_index, ((i - 1) % 2 == 0) ? 5'd1 : 5'd2);
            step();
        end
        req1_valid = 0;
        look();
        check("rr_tail_ready0", req0_ready, 1'b1);
        check("rr_tail_wr_idx", wr_index,   5'd2);
        step(); req0_valid = 0;
        look();
        check("rr_last_wr_idx", wr_index, 5'd1);

        // Write to x0 plus an issue of rd=0.
        step();
        req0_valid = 1; req0_index = 5'd0; req0_data = 32'hFFFF_FFFF;
        issue_en = 1; issue_rd = 5'd0; rd_index1 = 5'd0;
        look();
        check("x0_ready0", req0_ready, 1'b1);
        check("x0_haz1",   rd_hazard1, 1'b0);
        step(); req0_valid = 0; issue_en = 0;
        look();
        check("x0_wr_en", wr_en, 1'b0);
        check("x0_busy",  busy,  32'h0);

        // Scoreboard set, output-stage hazard, then clear.
        step(); issue_en = 1; issue_rd = 5'd7;
        look();
        check("sb_busy7_pre", busy[7], 1'b0);
        step(); issue_en = 0; rd_index1 = 5'd7;
        look();
        check("sb_busy7", busy[7],    1'b1);
        check("sb_haz1",  rd_hazard1, 1'b1);
        step(); req1_valid = 1; req1_index = 5'd7; req1_data = 32'h77;
        look();
        check("sb_ready1", req1_ready, 1'b1);
        step(); req1_valid = 0;
        look();
        check("sb_busy7_clr", busy[7],    1'b0);
        check("sb_wr_idx",    wr_index,   5'd7);
        check("sb_haz1_stg",  rd_hazard1, 1'b1);
        step();
        look();
        check("sb_haz1_done", rd_hazard1, 1'b0);

        // Set/clear collision on index 9.
        step(); issue_en = 1; issue_rd = 5'd9;
        look();
        step();
        req0_valid = 1; req0_index = 5'd9; req0_data = 32'h99; rd_index2 = 5'd9;
        look();
        check("col_busy9_pre", busy[9],    1'b1);
        check("col_ready0",    req0_ready, 1'b1);
        step(); issue_en = 0; req0_valid = 0;
        look();
        check("col_busy9", busy[9],    1'b1);
        check("col_haz2",  rd_hazard2, 1'b1);

        // Reset in the cycle after a transfer to index 3.
        step(); req0_valid = 1; req0_index = 5'd3; req0_data = 32'h33; rd_index1 = 5'd3;
        look();
        step(); req0_valid = 0; reset = 1;
        look();
        check("mrst_wr_en_pre", wr_en,    1'b1);
        check("mrst_wr_idx",    wr_index, 5'd3);
        step(); reset = 0;
        look();
        check("mrst_wr_en",  wr_en,      1'b0);
        check("mrst_busy",   busy,       32'h0);
        check("mrst_wr_dat", wr_data,    32'h0);
        check("mrst_haz1",   rd_hazard1, 1'b0);

        repeat (3) step();
        look();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
